wb_dmx_tx: RTL and testbench

Wishbone slave DMX512 transmitter on a conbus slave port, driven by the LM32 data master. The CPU fills a 512-byte slot buffer and control registers. The block then generates complete DMX512 frames (break, MAB, start code, N slots, 8N2 at 250 kbaud) on an RS-485 line driver. It raises an interrupt at end of frame for the dmx firmware.

---
 rtl/wb_dmx_tx.sv | 198 +++++++++++++++++++
 tb/tb_wb_dmx_tx.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dmx_tx.sv
// Wishbone slave DMX512 transmitter: 512-byte slot buffer plus control registers,
// emits break / MAB / start code / N slots as 8N2 at 250 kbaud with end-of-frame interrupt.
module wb_dmx_tx #(
  parameter int unsigned clk_freq   = 100000000,
  parameter int unsigned break_bits = 23,
  parameter int unsigned mab_bits   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic        intr,
  output logic        dmx_tx,
  output logic        dmx_de
);

  localparam int unsigned BIT_CYC = clk_freq / 250000;
  localparam logic [15:0] CNT_MAX  = 16'(BIT_CYC - 1);
  localparam logic [4:0]  BRK_LAST = 5'(break_bits - 1);
  localparam logic [4:0]  MAB_LAST = 5'(mab_bits - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BREAK, ST_MAB, ST_SLOT} state_t;
  state_t state, state_nx;

  logic        req, wr, is_buf, go_wr, cpu_ram, ram_we, fetch_grant;
  logic        tick, frame_end, start_frame, busy;
  logic [1:0]  reg_sel;
  logic [9:0]  nslots_wd, nslots_fix;
  logic [31:0] csr_rd, reg_rd;
  logic        rd_buf;
  logic        ctrl_cont, irq_en, done;
  logic [9:0]  nslots, nslots_sh, slot;
  logic [7:0]  startc, startc_sh, shreg, nxt_byte, ram_q;
  logic [15:0] cnt;
  logic [4:0]  bit_cnt;
  logic [2:0]  bit_idx;
  logic        fetch_pend, fetch_d;
  logic [8:0]  ram_addr;
  logic [7:0]  mem [512];
  logic        unused_bits;

  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:12], wb_adr_i[1:0], wb_dat_i[31:10]};

  assign req     = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign wr      = wb_stb_i & wb_cyc_i & wb_ack_o & wb_we_i;
  assign is_buf  = wb_adr_i[11];
  assign reg_sel = wb_adr_i[3:2];
  assign go_wr   = wr & ~is_buf & (reg_sel == 2'd0) & wb_dat_i[1];
  assign busy    = (state != ST_IDLE);

  assign nslots_wd  = wb_dat_i[9:0];
  assign nslots_fix = (nslots_wd == '0 || nslots_wd > 10'd512) ? 10'd512 : nslots_wd;

  // Single RAM port: CPU reads use the request cycle, CPU writes the ack cycle;
  // a pending slot fetch takes the first cycle the CPU leaves free.
  assign cpu_ram     = is_buf & wb_stb_i & wb_cyc_i & (wb_we_i ? wb_ack_o : ~wb_ack_o);
  assign ram_we      = cpu_ram & wb_we_i;
  assign ram_addr    = cpu_ram ? wb_adr_i[10:2] : slot[8:0];
  assign fetch_grant = fetch_pend & ~cpu_ram;

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= wb_dat_i[7:0];
    ram_q <= mem[ram_addr];
  end

  always_comb begin
    csr_rd = '0;
    case (reg_sel)
      2'd0: csr_rd[2:0] = {irq_en, 1'b0, ctrl_cont};
      2'd1: csr_rd[1:0] = {done, busy};
      2'd2: csr_rd[9:0] = nslots;
      default: csr_rd[7:0] = startc;
    endcase
  end

  assign wb_dat_o = rd_buf ? {24'b0, ram_q} : reg_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_ack_o  <= 1'b0;
      reg_rd    <= '0;
      rd_buf    <= 1'b0;
      ctrl_cont <= 1'b0;
      irq_en    <= 1'b0;
      done      <= 1'b0;
      nslots    <= 10'd512;
      startc    <= '0;
      intr      <= 1'b0;
    end else begin
      wb_ack_o <= wb_stb_i & wb_cyc_i & ~wb_ack_o;
      rd_buf   <= req & is_buf & ~wb_we_i;
      reg_rd   <= (req & ~is_buf & ~wb_we_i) ? csr_rd : '0;
      if (wr && !is_buf) begin
        case (reg_sel)
          2'd0: begin
            ctrl_cont <= wb_dat_i[0];
            irq_en    <= wb_dat_i[2];
          end
          2'd1: if (wb_dat_i[1]) done <= 1'b0;
          2'd2: nslots <= nslots_fix;
          default: startc <= wb_dat_i[7:0];
        endcase
      end
      if (frame_end) done <= 1'b1;
      intr <= done & irq_en;
    end
  end

  assign tick        = busy && (cnt == '0);
  assign frame_end   = (state == ST_SLOT) && tick && (bit_cnt == 5'd10) && (slot == nslots_sh);
  assign start_frame = (state_nx == ST_BREAK) && (state != ST_BREAK);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (go_wr || ctrl_cont) state_nx = ST_BREAK;
      ST_BREAK: if (tick && bit_cnt == BRK_LAST) state_nx = ST_MAB;
      ST_MAB:   if (tick && bit_cnt == MAB_LAST) state_nx = ST_SLOT;
      default:  if (frame_end) state_nx = ctrl_cont ? ST_BREAK : ST_IDLE;
    endcase
  end

  always_comb begin
    dmx_tx  = 1'b1;
    dmx_de  = 1'b1;
    bit_idx = bit_cnt[2:0] - 3'd1;
    case (state)
      ST_IDLE:  dmx_de = ctrl_cont;
      ST_BREAK: dmx_tx = 1'b0;
      ST_MAB:   dmx_tx = 1'b1;
      default: begin
        if (bit_cnt == '0)         dmx_tx = 1'b0;
        else if (bit_cnt <= 5'd8)  dmx_tx = shreg[bit_idx];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= CNT_MAX;
      bit_cnt    <= '0;
      slot       <= '0;
      shreg      <= '0;
      nslots_sh  <= 10'd512;
      startc_sh  <= '0;
      nxt_byte   <= '0;
      fetch_pend <= 1'b0;
      fetch_d    <= 1'b0;
    end else begin
      fetch_d <= fetch_grant;
      if (fetch_grant) fetch_pend <= 1'b0;
      if (fetch_d)     nxt_byte   <= ram_q;
      cnt <= (!busy || tick) ? CNT_MAX : cnt - 16'd1;
      if (start_frame) begin
        nslots_sh <= nslots;
        startc_sh <= startc;
        bit_cnt   <= '0;
      end else if (tick) begin
        case (state)
          ST_BREAK: bit_cnt <= (bit_cnt == BRK_LAST) ? '0 : bit_cnt + 5'd1;
          ST_MAB: begin
            if (bit_cnt == MAB_LAST) begin
              bit_cnt <= '0;
              slot    <= '0;
              shreg   <= startc_sh;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          ST_SLOT: begin
            if (bit_cnt == 5'd10) begin
              bit_cnt <= '0;
              slot    <= slot + 10'd1;
              shreg   <= nxt_byte;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              // Entering the first stop bit: prefetch the byte for the following slot.
              if (bit_cnt == 5'd8 && slot != nslots_sh) fetch_pend <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_dmx_tx.sv
// Self-checking bench for wb_dmx_tx at 4 clocks per bit; the expected line is
// derived from frame arithmetic over a buffer model.
module tb_wb_dmx_tx;
  localparam int BITC = 4;
  localparam int BRK  = 23;
  localparam int MAB  = 3;
  localparam logic [31:0] A_CTRL = 32'h0, A_STAT = 32'h4, A_NSL = 32'h8, A_STC = 32'hC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0, wb_ack_o;
  logic        intr, dmx_tx, dmx_de;

  int total = 0;
  int bad = 0;
  logic [7:0] buf_model [512];
  int ack_err = 0, ack_cnt = 0;
  logic prev_ack = 1'b0, prev_sc = 1'b0;
  int cyc = 0;

  wb_dmx_tx #(.clk_freq(1000000), .break_bits(23), .mab_bits(3)) dut (
    .clk(clk), .reset(reset), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
    .wb_ack_o(wb_ack_o), .intr(intr), .dmx_tx(dmx_tx), .dmx_de(dmx_de));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wb_ack_o && (prev_ack || !prev_sc)) ack_err++;
    if (wb_ack_o) ack_cnt++;
    prev_ack = wb_ack_o;
    prev_sc  = wb_stb_i && wb_cyc_i;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         output logic [31:0] rdat);
    logic ok;
    ok = 1'b0;
    rdat = '0;
    wb_adr_i = adr; wb_dat_i = dat; wb_we_i = we; wb_sel_i = 4'hF;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o) begin
        ok = 1'b1;
        rdat = wb_dat_o;
        break;
      end
    end
    @(posedge clk); #1;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL bus_ack: got no ack within 8 cycles, required ack (adr %0h)", adr);
    end
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, dat, dummy);
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] dat);
    wb_xfer(1'b0, adr, '0, dat);
  endtask

  function automatic logic [31:0] buf_adr(input int idx);
    return 32'h800 | 32'(idx << 2);
  endfunction

  function automatic logic exp_bit(input int b, input logic [7:0] sc);
    int k, j;
    logic [7:0] byt;
    if (b < BRK) return 1'b0;
    if (b < BRK + MAB) return 1'b1;
    k = (b - BRK - MAB) / 11;
    j = (b - BRK - MAB) % 11;
    byt = (k == 0) ? sc : buf_model[k-1];
    if (j == 0) return 1'b0;
    if (j <= 8) return byt[3'(j-1)];
    return 1'b1;
  endfunction

  // Waits (bounded) for the break edge, then samples every cycle of an N-slot frame.
  // err_c: -1 clean, -2 no frame started, else first mismatching cycle.
  task automatic capture_frame(input logic [7:0] sc, input int n, input int max_wait,
                               output int waited, output int err_c, output logic [1:0] got);
    int len;
    waited = 0;
    err_c  = -1;
    got    = 2'b00;
    while (dmx_tx !== 1'b0 && waited < max_wait) begin
      @(posedge clk); #1;
      waited++;
    end
    if (dmx_tx !== 1'b0) begin
      err_c = -2;
      return;
    end
    len = BITC * (BRK + MAB + 11 * (n + 1));
    for (int c = 0; c < len; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (err_c == -1 && (dmx_tx !== exp_bit(c / BITC, sc) || dmx_de !== 1'b1)) begin
        err_c = c;
        got = {dmx_tx, dmx_de};
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int errs;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({dmx_tx, dmx_de, wb_ack_o, intr} !== 4'b1000 || wb_dat_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: got tx/de/ack/intr=%b dat=%0h, required 1000 dat=0",
               {dmx_tx, dmx_de, wb_ack_o, intr}, wb_dat_o);
    end
    reset = 1'b0;
    rd(A_STAT, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_status: got %0h required 0", d); end
    rd(A_NSL, d); total++;
    if (d !== 32'd512) begin bad++; $display("FAIL reset_nslots: got %0d required 512", d); end
    rd(A_CTRL, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl: got %0h required 0", d); end
    rd(A_STC, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_startc: got %0h required 0", d); end

    wr(A_CTRL, 32'h2);
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (dmx_tx !== 1'b0 || dmx_de !== 1'b1) begin
      bad++; $display("FAIL break_active: got tx=%b de=%b required tx=0 de=1", dmx_tx, dmx_de);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (dmx_tx !== 1'b1 || dmx_de !== 1'b0) begin
      bad++; $display("FAIL reset_mid_break: got tx=%b de=%b required tx=1 de=0", dmx_tx, dmx_de);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if (wb_ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b required 0", wb_ack_o); end
    rd(A_STAT, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset2_status: got %0h required 0", d); end
    rd(A_NSL, d); total++;
    if (d !== 32'd512) begin bad++; $display("FAIL reset2_nslots: got %0d required 512", d); end
    errs = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (dmx_tx !== 1'b1 || dmx_de !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL reset_line_idle: got %0d busy cycles required 0", errs); end
  endtask

  task automatic test_single_frame();
    logic [31:0] d;
    int w, e;
    logic [1:0] g;
    wr(A_NSL, 32'd2);
    wr(A_STC, 32'h00);
    buf_model[0] = 8'hA5; wr(buf_adr(0), 32'hA5);
    buf_model[1] = 8'h3C; wr(buf_adr(1), 32'h3C);
    wr(A_CTRL, 32'h2);
    capture_frame(8'h00, 2, 4, w, e, g);
    total++;
    if (e != -1 || w > 2) begin
      bad++; $display("FAIL single_frame: got err_cycle=%0d wait=%0d txde=%b required -1 wait<=2", e, w, g);
    end
    @(posedge clk); #1;
    total++;
    if (dmx_tx !== 1'b1 || dmx_de !== 1'b0) begin
      bad++; $display("FAIL single_end_line: got tx=%b de=%b required 1 0", dmx_tx, dmx_de);
    end
    rd(A_STAT, d); total++;
    if (d !== 32'h2) begin bad++; $display("FAIL single_done: got %0h required 2", d); end
    wr(A_STAT, 32'h2);
    rd(A_STAT, d); total++;
    if (d !== 32'h0) begin bad++; $display("FAIL single_w1c: got %0h required 0", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    int w, e;
    logic [1:0] g;
    wr(A_CTRL, 32'h6);
    capture_frame(8'h00, 2, 4, w, e, g);
    total++;
    if (e != -1) begin bad++; $display("FAIL irq_frame: got err_cycle=%0d txde=%b required -1", e, g); end
    @(posedge clk); #1;
    total++;
    if (intr !== 1'b0) begin bad++; $display("FAIL irq_lag: got %b required 0", intr); end
    @(posedge clk); #1;
    total++;
    if (intr !== 1'b1) begin bad++; $display("FAIL irq_rise: got %b required 1", intr); end
    rd(A_STAT, d); total++;
    if (d !== 32'h2) begin bad++; $display("FAIL irq_status: got %0h required 2", d); end
    wr(A_STAT, 32'h2);
    total++;
    if (intr !== 1'b1) begin bad++; $display("FAIL irq_hold: got %b required 1", intr); end
    @(posedge clk); #1;
    total++;
    if (intr !== 1'b0) begin bad++; $display("FAIL irq_fall: got %b required 0", intr); end
    wr(A_CTRL, 32'h0);
  endtask

  task automatic test_continuous();
    logic [31:0] d;
    int w, e, errs;
    logic [1:0] g;
    buf_model[0] = 8'($urandom_range(255, 0));
    wr(buf_adr(0), {24'b0, buf_model[0]});
    wr(A_NSL, 32'd1);
    wr(A_STC, 32'h00);
    wr(A_CTRL, 32'h1);
    fork
      capture_frame(8'h00, 1, 4, w, e, g);
      begin
        repeat (40) @(posedge clk);
        #1;
        wr(A_STC, 32'h17);
      end
    join
    total++;
    if (e != -1) begin bad++; $display("FAIL cont_frame1: got err_cycle=%0d txde=%b required -1", e, g); end
    fork
      capture_frame(8'h17, 1, 4, w, e, g);
      begin
        repeat (40) @(posedge clk);
        #1;
        wr(A_CTRL, 32'h0);
      end
    join
    total++;
    if (e != -1 || w != 1) begin
      bad++; $display("FAIL cont_frame2: got err_cycle=%0d wait=%0d txde=%b required -1 wait=1", e, w, g);
    end
    errs = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (dmx_tx !== 1'b1 || dmx_de !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL cont_stop: got %0d active cycles required 0", errs); end
    rd(A_STAT, d); total++;
    if (d !== 32'h2) begin bad++; $display("FAIL cont_status: got %0h required 2", d); end
    wr(A_STAT, 32'h2);
  endtask

  task automatic test_boundaries();
    logic [31:0] d;
    int w, e, errs;
    logic [1:0] g;
    logic [7:0] sc;
    int wv [7] = '{0, 513, 600, 1023, 512, 1, 300};
    int xv [7] = '{512, 512, 512, 512, 512, 1, 300};
    for (int i = 0; i < 7; i++) begin
      wr(A_NSL, 32'(wv[i]));
      rd(A_NSL, d); total++;
      if (d !== 32'(xv[i])) begin
        bad++; $display("FAIL nslots_clamp: wrote %0d got %0d required %0d", wv[i], d, xv[i]);
      end
    end
    for (int i = 0; i < 512; i++) begin
      buf_model[i] = (i == 511) ? 8'hFF : 8'($urandom_range(255, 0));
      wr(buf_adr(i), {24'b0, buf_model[i]});
    end
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx = (i == 3) ? 511 : int'($urandom_range(510, 0));
      rd(buf_adr(idx), d); total++;
      if (d !== {24'b0, buf_model[idx]}) begin
        bad++; $display("FAIL buf_read: slot idx %0d got %0h required %0h", idx, d, buf_model[idx]);
      end
    end
    sc = 8'($urandom_range(255, 0));
    wr(A_STC, {24'b0, sc});
    wr(A_NSL, 32'd512);
    wr(A_CTRL, 32'h2);
    fork
      capture_frame(sc, 512, 4, w, e, g);
      begin
        repeat (300) @(posedge clk);
        #1;
        wr(A_CTRL, 32'h2);
      end
    join
    total++;
    if (e != -1) begin bad++; $display("FAIL frame_512: got err_cycle=%0d txde=%b required -1", e, g); end
    errs = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (dmx_tx !== 1'b1 || dmx_de !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL go_while_busy: got %0d active cycles required 0", errs); end
    wr(A_STAT, 32'h2);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int w, e, nx, t0, a_cnt0, a_err0;
    logic [1:0] g;
    logic [7:0] sc;
    for (int i = 0; i < 16; i++) begin
      buf_model[i] = 8'($urandom_range(255, 0));
      wr(buf_adr(i), {24'b0, buf_model[i]});
    end
    sc = 8'($urandom_range(255, 0));
    wr(A_STC, {24'b0, sc});
    wr(A_NSL, 32'd16);
    wr(A_CTRL, 32'h2);
    t0 = cyc;
    a_cnt0 = ack_cnt;
    a_err0 = ack_err;
    nx = 0;
    fork
      capture_frame(sc, 16, 4, w, e, g);
      begin
        for (int k = 0; k < 150; k++) begin
          int idx;
          if ((cyc - t0) < 150 && $urandom_range(1, 0) == 1) begin
            idx = int'($urandom_range(15, 8));
            buf_model[idx] = 8'($urandom_range(255, 0));
            wr(buf_adr(idx), {24'b0, buf_model[idx]});
          end else begin
            idx = int'($urandom_range(15, 0));
            rd(buf_adr(idx), d); total++;
            if (d !== {24'b0, buf_model[idx]}) begin
              bad++; $display("FAIL b2b_read: slot idx %0d got %0h required %0h", idx, d, buf_model[idx]);
            end
          end
          nx++;
          if ($urandom_range(3, 0) == 0) begin
            @(posedge clk); #1;
          end
        end
      end
    join
    total++;
    if (e != -1) begin bad++; $display("FAIL b2b_frame: got err_cycle=%0d txde=%b required -1", e, g); end
    total++;
    if (ack_err != a_err0) begin
      bad++; $display("FAIL ack_pulse: got %0d bad acks required 0", ack_err - a_err0);
    end
    total++;
    if (ack_cnt - a_cnt0 != nx) begin
      bad++; $display("FAIL ack_count: got %0d required %0d", ack_cnt - a_cnt0, nx);
    end
    wr(A_STAT, 32'h2);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_irq();
    test_continuous();
    test_boundaries();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
